// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding, operation kind
// and the default burst length.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Matches the 3-bit register counter used by load/store-multiple.
  localparam int BURST_LEN = 8;

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous word RAM with a registered read port.
// Contents are never cleared; only the read register honours reset.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read data holds its last value until the next read access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: single-word and burst reads/writes with a fixed
// number of wait states before every beat, reporting completion by pulses.
//
// state    | meaning
// S_IDLE   | waiting for exactly one of mem_rd/mem_wr
// S_WAIT   | inserting WAIT_CYCLES wait states before a beat
// S_ACCESS | one-cycle RAM access for the current beat
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_LEN   = mem_pkg::BURST_LEN
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              burst,
  input  logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvalid,
  output logic              mem_wack,
  output logic              mem_last,
  output logic              mem_busy,
  output logic              mem_err
);

  import mem_pkg::*;

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam state_e FIRST_ST = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              burst_q, burst_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rvalid_q, rvalid_d;
  logic              wack_q, wack_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ram_en;
  logic              is_last;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[15:ADDR_W];
  assign is_last = !burst_q || (beat_q == BEAT_LAST);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    rvalid_d = 1'b0;
    wack_d   = 1'b0;
    last_d   = 1'b0;
    err_d    = 1'b0;
    ram_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_rd && mem_wr) begin
          err_d = 1'b1;
        end else if (mem_rd || mem_wr) begin
          op_d    = mem_wr ? OP_WR : OP_RD;
          addr_d  = mem_addr[ADDR_W-1:0];
          burst_d = burst;
          beat_d  = '0;
          wait_d  = '0;
          state_d = FIRST_ST;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_ACCESS;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_ACCESS: begin
        ram_en   = 1'b1;
        rvalid_d = (op_q == OP_RD);
        wack_d   = (op_q == OP_WR);
        if (is_last) begin
          last_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + BEAT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = FIRST_ST;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (proc_rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_RD;
      addr_q   <= '0;
      burst_q  <= 1'b0;
      beat_q   <= '0;
      wait_q   <= '0;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      wack_q   <= wack_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // An access coinciding with reset is dropped so an aborted beat never commits.
  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst  (proc_rst),
    .en   (ram_en && !proc_rst),
    .we   (op_q == OP_WR),
    .addr (addr_q),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign mem_rvalid = rvalid_q;
  assign mem_wack   = wack_q;
  assign mem_last   = last_q;
  assign mem_busy   = busy_q;
  assign mem_err    = err_q;

endmodule
